// File: rtl/hps_pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear and a pulse-burst generator XOR-ed onto out_port.
// Optional IRQ output and IRQEN register at address 7 when HPS_PIO_PULSE_IRQ_EN is defined.
`timescale 1ns/1ps
module hps_pio_pulse_out #(
    parameter int                    DATA_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    PW_BITS     = 16,
    parameter int                    CNT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
`ifdef HPS_PIO_PULSE_IRQ_EN
    output logic                  irq,
`endif
    output logic [DATA_WIDTH-1:0] out_port
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [PW_BITS-1:0]  PW_ONE  = PW_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] data, mask;
    logic [PW_BITS-1:0]    pw, pw_eff, pw_lat, phase, phase_next;
    logic [CNT_BITS-1:0]   cnt, pulses, pulses_next;
    logic                  done, done_next, done_set;
    logic                  wr, start, abort;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign pw_eff    = (pw == '0) ? PW_ONE : pw;
    assign start     = wr && (address == 3'd3) && (state == IDLE)
                       && (writedata[DATA_WIDTH-1:0] != '0) && (cnt != '0);
    assign abort     = wr && (address == 3'd1) && writedata[1] && (state != IDLE);
    assign unused_wd = ^writedata;

    // Software-visible configuration; DATA/SET/CLR act immediately, even mid-burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
            pw   <= PW_ONE;
            cnt  <= '0;
        end else if (wr) begin
            // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
            case (address)
                3'd0:    data <= writedata[DATA_WIDTH-1:0];
                3'd2:    pw   <= writedata[PW_BITS-1:0];
                3'd4:    data <= data | writedata[DATA_WIDTH-1:0];
                3'd5:    data <= data & ~writedata[DATA_WIDTH-1:0];
                3'd6:    cnt  <= writedata[CNT_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            phase  <= PW_ONE;
            pulses <= '0;
            pw_lat <= PW_ONE;
            mask   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            phase  <= phase_next;
            pulses <= pulses_next;
            done   <= done_next;
            if (start) begin
                pw_lat <= pw_eff;
                mask   <= writedata[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_next  = state;
        phase_next  = phase;
        pulses_next = pulses;
        done_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = HIGH;
                    phase_next  = pw_eff;
                    pulses_next = cnt;
                end
            end
            HIGH: begin
                if (phase == PW_ONE) begin
                    state_next = LOW;
                    phase_next = pw_lat;
                end else begin
                    phase_next = phase - PW_ONE;
                end
            end
            LOW: begin
                if (phase == PW_ONE) begin
                    if (pulses == CNT_ONE) begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        state_next  = HIGH;
                        phase_next  = pw_lat;
                        pulses_next = pulses - CNT_ONE;
                    end
                end else begin
                    phase_next = phase - PW_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            done_set   = 1'b0;
        end
        // Completion beats a same-edge done-clear.
        if (done_set)
            done_next = 1'b1;
        else if (wr && (address == 3'd1) && writedata[0])
            done_next = 1'b0;
        else
            done_next = done;
    end

    assign out_port = data ^ (mask & {DATA_WIDTH{state == HIGH}});

`ifdef HPS_PIO_PULSE_IRQ_EN
    logic irq_en, irq_en_next;

    assign irq_en_next = (wr && (address == 3'd7)) ? writedata[0] : irq_en;

    // irq follows done_next so it rises with done and drops on the clearing edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_next;
            irq    <= done_next & irq_en_next;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[DATA_WIDTH-1:0] = data;
            3'd1: readdata[1:0]            = {done, state != IDLE};
            3'd2: readdata[PW_BITS-1:0]    = pw;
            3'd3: readdata[DATA_WIDTH-1:0] = mask;
            3'd6: readdata[CNT_BITS-1:0]   = cnt;
`ifdef HPS_PIO_PULSE_IRQ_EN
            3'd7: readdata[0]              = irq_en;
`endif
            default: ;
        endcase
    end

endmodule
